tt_um_jimktrains_vslc_sequencer: RTL and testbench
==================================================

TT_UM_JIMKTRAINS_VSLC_SEQUENCER -- requirements
Module: tt_um_jimktrains_vslc_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 16, program memory depth in bytes (power of two, 2..64).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port run, input, 1, level request to execute scans continuously.
REQ-005 SHALL have port load_en, input, 1, level request for program load mode.
REQ-006 SHALL have port load_valid, input, 1, strobe qualifying load_data.
REQ-007 SHALL have port load_data, input, 8, program byte to store.
REQ-008 SHALL have port ui_in, input, 8, raw external inputs.
REQ-009 SHALL have port instr, output, 8, registered instruction to executor.
REQ-010 SHALL have port instr_ready, output, 1, registered one-cycle qualifier per issued instr.
REQ-011 SHALL have port ui_in_sampled, output, 8, input image frozen for the current scan.
REQ-012 SHALL have port ui_in_prev, output, 8, input image of the previous scan.
REQ-013 SHALL have port pc, output, $clog2(PROG_DEPTH), index of last issued instruction.
REQ-014 SHALL have ports scan_done (1-cycle pulse), busy (1 while not IDLE), load_err (sticky overflow flag), all outputs.

Function
REQ-015 SHALL implement states IDLE, LOAD, SAMPLE, ISSUE, END; all outputs registered on posedge clk so the executor's negedge sampling sees stable values.
REQ-016 IDLE: load_en=1 -> LOAD with wr_ptr=0, load_err=0; else run=1 and prog_len!=0 -> SAMPLE; load_en has priority over run.
REQ-017 LOAD: each cycle with load_valid=1 writes load_data to mem[wr_ptr], wr_ptr+1; writes beyond PROG_DEPTH bytes dropped and load_err set.
REQ-018 LOAD: load_en=0 -> prog_len=wr_ptr (saturated at PROG_DEPTH), -> IDLE; load_valid ignored that cycle.
REQ-019 SAMPLE (one cycle): ui_in_prev <= ui_in_sampled, ui_in_sampled <= ui_in, pc <= 0, -> ISSUE.
REQ-020 ISSUE: each cycle drives instr=mem[pc], instr_ready=1; pc increments; after issuing index prog_len-1 -> END.
REQ-021 END (one cycle): instr_ready=0, scan_done=1; run=1 -> SAMPLE, else -> IDLE.
REQ-022 Scan of length L SHALL occupy exactly L+2 cycles; back-to-back scans with no gap cycles.
REQ-023 instr_ready SHALL be 0 in IDLE, LOAD, SAMPLE, END; instr holds its last value when instr_ready=0.
REQ-024 run deasserted mid-scan SHALL NOT abort; the scan completes and END returns to IDLE.
REQ-025 load_en while not IDLE SHALL be ignored until IDLE is reached.
REQ-026 prog_len=0 with run=1 SHALL keep the block in IDLE, busy=0.
REQ-027 ui_in_sampled/ui_in_prev SHALL change only in SAMPLE.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, pc=0, wr_ptr=0, prog_len=0, instr=0x00, instr_ready=0, ui_in_sampled=0, ui_in_prev=0, scan_done=0, busy=0, load_err=0.
REQ-029 Program memory contents SHALL NOT be reset; prog_len=0 renders them inert.
REQ-030 Reset asserted mid-scan or mid-load SHALL abandon the operation with no further instr_ready pulse.

Configuration
REQ-031 Macro VSLC_SEQ_STEP_EN SHALL, when defined, add input port step (1 bit); in ISSUE an instruction is issued only on the cycle after a detected step rising edge, otherwise instr_ready=0 and pc holds.
REQ-032 Without VSLC_SEQ_STEP_EN the step port SHALL be absent and ISSUE free-runs one instruction per cycle.

Verification
REQ-033 Load 0x00,0x91,0x18 with load_en/load_valid, drop load_en, pulse run -> prog_len=3, instr sequence 0x00,0x91,0x18 on 3 consecutive instr_ready cycles, scan_done 1 cycle later.
REQ-034 run held, ui_in=0x01 then 0x03 between scans -> scan 2 shows ui_in_prev=0x01, ui_in_sampled=0x03; scan period exactly 5 cycles.
REQ-035 Load PROG_DEPTH+2 bytes -> load_err=1, prog_len=PROG_DEPTH, last 2 bytes absent from issued stream.
REQ-036 run drops after 1st instruction of a 3-byte program -> remaining 2 issued, scan_done, then IDLE, busy=0.
REQ-037 rst_n low during ISSUE (pc=1) -> immediate instr_ready=0, all outputs reset; run=1 after release stays IDLE (prog_len=0).
REQ-038 With VSLC_SEQ_STEP_EN, 3-byte program, 3 step pulses 10 cycles apart -> exactly one instr_ready per pulse, pc 0,1,2, then scan_done.

Source files
------------

// File: rtl/tt_um_jimktrains_vslc_sequencer_if.sv
// Host/executor bundle for the VSLC scan sequencer: load port, run control,
// raw inputs, and the registered instruction stream. Macro: VSLC_SEQ_STEP_EN adds step.
`default_nettype none

interface tt_um_jimktrains_vslc_sequencer_if #(
  parameter int PROG_DEPTH = 16
);
  localparam int PW = $clog2(PROG_DEPTH);

  logic          run;
  logic          load_en;
  logic          load_valid;
  logic [7:0]    load_data;
  logic [7:0]    ui_in;
`ifdef VSLC_SEQ_STEP_EN
  logic          step;
`endif
  logic [7:0]    instr;
  logic          instr_ready;
  logic [7:0]    ui_in_sampled;
  logic [7:0]    ui_in_prev;
  logic [PW-1:0] pc;
  logic          scan_done;
  logic          busy;
  logic          load_err;

  modport master (
`ifdef VSLC_SEQ_STEP_EN
    output step,
`endif
    output run, load_en, load_valid, load_data, ui_in,
    input  instr, instr_ready, ui_in_sampled, ui_in_prev, pc, scan_done, busy, load_err
  );

  modport slave (
`ifdef VSLC_SEQ_STEP_EN
    input  step,
`endif
    input  run, load_en, load_valid, load_data, ui_in,
    output instr, instr_ready, ui_in_sampled, ui_in_prev, pc, scan_done, busy, load_err
  );
endinterface

`default_nettype wire

// File: rtl/tt_um_jimktrains_vslc_sequencer.sv
// +--------------------------------------------------------------------------+
// | tt_um_jimktrains_vslc_sequencer                                          |
// | Loads a byte program, then per scan freezes ui_in and streams the        |
// | program to the executor. Macro VSLC_SEQ_STEP_EN: step-gated issue.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tt_um_jimktrains_vslc_sequencer #(
  parameter int PROG_DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  tt_um_jimktrains_vslc_sequencer_if.slave bus
);
  localparam int PW = $clog2(PROG_DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(PROG_DEPTH);
  localparam logic [PW:0] C_ONE   = (PW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SAMPLE = 3'd2,
    S_ISSUE  = 3'd3,
    S_END    = 3'd4
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [PROG_DEPTH];
  logic [PW:0]   r_wr_ptr;
  logic [PW:0]   r_prog_len;
  logic [PW:0]   r_idx;
  logic [PW-1:0] r_pc;
  logic [7:0]    r_instr;
  logic          r_instr_ready;
  logic [7:0]    r_ui_sampled;
  logic [7:0]    r_ui_prev;
  logic          r_scan_done;
  logic          r_busy;
  logic          r_load_err;
  logic          w_issue_ok;
  logic          w_mem_we;
  logic          w_last;

`ifdef VSLC_SEQ_STEP_EN
  logic r_step_d;
  logic r_step_rise;

  // Issue lands on the cycle after the registered rising edge of step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_d    <= 1'b0;
      r_step_rise <= 1'b0;
    end else begin
      r_step_d    <= bus.step;
      r_step_rise <= bus.step & ~r_step_d;
    end
  end

  assign w_issue_ok = r_step_rise;
`else
  assign w_issue_ok = 1'b1;
`endif

  // wr_ptr saturates at PROG_DEPTH, so it doubles as the program length.
  assign w_mem_we = (r_state == S_LOAD) && bus.load_en && bus.load_valid
                    && (r_wr_ptr != C_DEPTH);
  assign w_last   = ((r_idx + C_ONE) == r_prog_len);

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr[PW-1:0]] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_prog_len    <= '0;
      r_idx         <= '0;
      r_pc          <= '0;
      r_instr       <= 8'h00;
      r_instr_ready <= 1'b0;
      r_ui_sampled  <= 8'h00;
      r_ui_prev     <= 8'h00;
      r_scan_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      r_instr_ready <= 1'b0;
      r_scan_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.load_en) begin
            r_state    <= S_LOAD;
            r_wr_ptr   <= '0;
            r_load_err <= 1'b0;
            r_busy     <= 1'b1;
          end else if (bus.run && (r_prog_len != '0)) begin
            r_state <= S_SAMPLE;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!bus.load_en) begin
            r_prog_len <= r_wr_ptr;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
          end else if (bus.load_valid) begin
            if (r_wr_ptr != C_DEPTH) begin
              r_wr_ptr <= r_wr_ptr + C_ONE;
            end else begin
              r_load_err <= 1'b1;
            end
          end
        end
        S_SAMPLE: begin
          r_ui_prev    <= r_ui_sampled;
          r_ui_sampled <= bus.ui_in;
          r_pc         <= '0;
          r_idx        <= '0;
          r_state      <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_issue_ok) begin
            r_instr       <= r_mem[r_idx[PW-1:0]];
            r_instr_ready <= 1'b1;
            r_pc          <= r_idx[PW-1:0];
            r_idx         <= r_idx + C_ONE;
            if (w_last) begin
              r_state <= S_END;
            end
          end
        end
        S_END: begin
          r_scan_done <= 1'b1;
          if (bus.run) begin
            r_state <= S_SAMPLE;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr         = r_instr;
  assign bus.instr_ready   = r_instr_ready;
  assign bus.ui_in_sampled = r_ui_sampled;
  assign bus.ui_in_prev    = r_ui_prev;
  assign bus.pc            = r_pc;
  assign bus.scan_done     = r_scan_done;
  assign bus.busy          = r_busy;
  assign bus.load_err      = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_jimktrains_vslc_sequencer.sv
// Scoreboard bench for the VSLC sequencer: random programs and input images,
// expected instruction stream built from the program/scan rules.
`default_nettype none

module tb_tt_um_jimktrains_vslc_sequencer;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [7:0] instr;
    logic [3:0] pc;
    logic [7:0] samp;
    logic [7:0] prev;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tt_um_jimktrains_vslc_sequencer_if #(.PROG_DEPTH(DEPTH)) bus ();

  tt_um_jimktrains_vslc_sequencer #(.PROG_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  int         period_q[$];
  logic [7:0] prog[$];
  logic [7:0] m_samp = 8'h00;
  logic [7:0] m_prev = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s actual=%s required=none", name, what);
  endtask

  // Monitor: pop one expectation per issued instruction / scan_done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_instr", "instr_ready");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("instr", {24'd0, bus.instr}, {24'd0, e.instr});
          chk("pc", {28'd0, bus.pc}, {28'd0, e.pc});
          chk("ui_in_sampled", {24'd0, bus.ui_in_sampled}, {24'd0, e.samp});
          chk("ui_in_prev", {24'd0, bus.ui_in_prev}, {24'd0, e.prev});
        end
      end
      if (bus.scan_done) begin
        if (period_q.size() == 0) begin
          fail("unexpected_scan_done", "scan_done");
        end else begin
          int p;
          p = period_q.pop_front();
          if (p != 0) chk("scan_period", cyc - last_done, p);
        end
        last_done = cyc;
      end
    end
  end

  task automatic load_prog(input logic [7:0] bytes[$]);
    @(negedge clk);
    bus.load_en = 1'b1;
    @(negedge clk);
    foreach (bytes[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.load_valid = 1'b0;
        @(negedge clk);
      end
      bus.load_valid = 1'b1;
      bus.load_data  = bytes[i];
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    bus.load_en    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    prog.delete();
    foreach (bytes[i]) if (i < DEPTH) prog.push_back(bytes[i]);
    chk("load_err", {31'd0, bus.load_err}, (bytes.size() > DEPTH) ? 32'd1 : 32'd0);
    chk("busy_after_load", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic push_scan(input logic [7:0] v);
    m_prev = m_samp;
    m_samp = v;
    foreach (prog[i]) exp_q.push_back('{prog[i], 4'(i), m_samp, m_prev});
  endtask

  task automatic wait_issue(input logic [3:0] want_pc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.instr_ready && bus.pc == want_pc) begin
        ok = 1'b1;
        return;
      end
    end
    fail("issue_timeout", "no_issue");
  endtask

  // Continuous run for n scans; run drops after the first issue of the last scan.
  task automatic run_burst(input int n, input logic [7:0] v0);
    logic [7:0] v;
    bit ok;
    bus.ui_in = v0;
    push_scan(v0);
    period_q.push_back(0);
    bus.run = 1'b1;
    for (int s = 0; s < n; s++) begin
      wait_issue(4'd0, ok);
      if (!ok) break;
      if (s < n - 1) begin
        v = 8'($urandom);
        bus.ui_in = v;
        push_scan(v);
        period_q.push_back(prog.size() + 2);
      end else begin
        bus.run = 1'b0;
      end
    end
    bus.run = 1'b0;
    repeat (DEPTH + 8) @(negedge clk);
    chk("busy_idle_after_burst", {31'd0, bus.busy}, 32'd0);
    chk("instr_queue_drained", exp_q.size(), 32'd0);
    chk("done_queue_drained", period_q.size(), 32'd0);
    exp_q.delete();
    period_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instr_ready"}, {31'd0, bus.instr_ready}, 32'd0);
    chk({tag, "_instr"}, {24'd0, bus.instr}, 32'd0);
    chk({tag, "_pc"}, {28'd0, bus.pc}, 32'd0);
    chk({tag, "_sampled"}, {24'd0, bus.ui_in_sampled}, 32'd0);
    chk({tag, "_prev"}, {24'd0, bus.ui_in_prev}, 32'd0);
    chk({tag, "_scan_done"}, {31'd0, bus.scan_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_load_err"}, {31'd0, bus.load_err}, 32'd0);
  endtask

  initial begin
    logic [7:0] bytes[$];
    bit ok;
    int len;
    bus.run = 1'b0;
    bus.load_en = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = 8'h00;
    bus.ui_in = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Empty program: run must not leave IDLE.
    bus.run = 1'b1;
    repeat (8) @(negedge clk);
    chk("empty_prog_busy", {31'd0, bus.busy}, 32'd0);
    bus.run = 1'b0;

    bytes = '{8'h00, 8'h91, 8'h18};
    load_prog(bytes);
    run_burst(3, 8'h01);

    // Overflow: last two bytes must never be issued.
    bytes.delete();
    for (int i = 0; i < DEPTH + 2; i++) bytes.push_back(8'($urandom));
    load_prog(bytes);
    run_burst(2, 8'($urandom));

    for (int t = 0; t < 6; t++) begin
      bytes.delete();
      len = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
      load_prog(bytes);
      run_burst($urandom_range(1, 3), 8'($urandom));
    end

    // Reset in the middle of a scan.
    bytes = '{8'h3c, 8'h5a, 8'ha5};
    load_prog(bytes);
    bus.ui_in = 8'h77;
    push_scan(8'h77);
    period_q.push_back(0);
    bus.run = 1'b1;
    wait_issue(4'd1, ok);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midscan_reset");
    exp_q.delete();
    period_q.delete();
    prog.delete();
    m_samp = 8'h00;
    m_prev = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_idle_busy", {31'd0, bus.busy}, 32'd0);
    bus.run = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
